hazard_scoreboard: RTL and testbench

Parametrised RAW-hazard scoreboard for the vector CPU pipeline. Sits beside the Decode stage, tracks the destination register of every in-flight instruction between Execute and Write Back, and stalls issue while any source register of the decoded instruction has a pending write. It also squashes the decoded instruction on a taken branch and keeps stall and pending statistics. Scalar and vector register files are tracked separately through a type bit.

---
 rtl/hazard_scoreboard_if.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 96 +++++++++
 tb/tb_hazard_scoreboard.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode <-> hazard scoreboard bundle. Decode is the master and drives the decoded-instruction fields.
// The scoreboard is the slave and returns the stall, flush and accept decisions plus pipeline statistics.
interface hazard_scoreboard_if #(
  parameter int REG_ADDRESS_WIDTH = 4,
  parameter int PIPE_DEPTH        = 3,
  parameter int COUNT_WIDTH       = 16
);
  localparam int PendingWidth = $clog2(PIPE_DEPTH + 1);

  logic                         issueValid;
  logic                         reg1Used;
  logic                         reg2Used;
  logic [REG_ADDRESS_WIDTH-1:0] reg1Address;
  logic [REG_ADDRESS_WIDTH-1:0] reg2Address;
  logic                         isScalarReg1;
  logic                         isScalarReg2;
  logic                         writesReg;
  logic [REG_ADDRESS_WIDTH-1:0] regDestinationAddress;
  logic                         isScalarOutput;
  logic                         takeBranchE;
  logic                         stallD;
  logic                         flushD;
  logic                         issueAccept;
  logic                         busy;
  logic [PendingWidth-1:0]      pendingCount;
  logic [COUNT_WIDTH-1:0]       stallCycles;

  modport master (
    output issueValid, reg1Used, reg2Used, reg1Address, reg2Address,
           isScalarReg1, isScalarReg2, writesReg, regDestinationAddress,
           isScalarOutput, takeBranchE,
    input  stallD, flushD, issueAccept, busy, pendingCount, stallCycles
  );

  modport slave (
    input  issueValid, reg1Used, reg2Used, reg1Address, reg2Address,
           isScalarReg1, isScalarReg2, writesReg, regDestinationAddress,
           isScalarOutput, takeBranchE,
    output stallD, flushD, issueAccept, busy, pendingCount, stallCycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// RAW-hazard scoreboard beside Decode. stallD/flushD/issueAccept are combinational; busy, pendingCount
// and stallCycles are registered. Stalls resolve by waiting for the producer slot to drain; no backpressure upstream of Decode.
module hazard_scoreboard #(
  parameter int REG_ADDRESS_WIDTH = 4,
  parameter int PIPE_DEPTH        = 3,
  parameter bit WB_BYPASS         = 1'b0,
  parameter int COUNT_WIDTH       = 16
) (
  input logic                clock,
  input logic                reset,
  hazard_scoreboard_if.slave sb
);
  localparam int PendingWidth = $clog2(PIPE_DEPTH + 1);
  // A write-before-read register file lets the Write Back slot be ignored for matching.
  localparam int MatchDepth   = WB_BYPASS ? PIPE_DEPTH - 1 : PIPE_DEPTH;

  typedef struct packed {
    logic                         valid;
    logic                         is_scalar;
    logic [REG_ADDRESS_WIDTH-1:0] addr;
  } slot_t;

  slot_t                   r_slot      [PIPE_DEPTH];
  slot_t                   w_slot_next [PIPE_DEPTH];
  logic                    r_busy;
  logic [PendingWidth-1:0] r_pending;
  logic [COUNT_WIDTH-1:0]  r_stall_cycles;

  logic                    w_match1;
  logic                    w_match2;
  logic                    w_hazard;
  logic                    w_stall;
  logic                    w_accept;
  logic                    w_busy_next;
  logic [PendingWidth-1:0] w_pending_next;

  always_comb begin
    w_match1 = 1'b0;
    w_match2 = 1'b0;
    for (int k = 0; k < MatchDepth; k++) begin
      if (r_slot[k].valid && (r_slot[k].is_scalar == sb.isScalarReg1) &&
          (r_slot[k].addr == sb.reg1Address)) begin
        w_match1 = 1'b1;
      end
      if (r_slot[k].valid && (r_slot[k].is_scalar == sb.isScalarReg2) &&
          (r_slot[k].addr == sb.reg2Address)) begin
        w_match2 = 1'b1;
      end
    end
  end

  assign w_hazard = sb.issueValid & ((sb.reg1Used & w_match1) | (sb.reg2Used & w_match2));
  assign w_stall  = w_hazard & ~sb.takeBranchE;
  assign w_accept = sb.issueValid & ~w_hazard & ~sb.takeBranchE;

  // Slots shift every cycle; a stalled or squashed instruction leaves a bubble in Execute.
  always_comb begin
    w_slot_next[0] = {sb.writesReg & w_accept, sb.isScalarOutput, sb.regDestinationAddress};
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      w_slot_next[k] = r_slot[k-1];
    end
    w_pending_next = '0;
    w_busy_next    = 1'b0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      w_pending_next = w_pending_next + PendingWidth'(w_slot_next[k].valid);
      w_busy_next    = w_busy_next | w_slot_next[k].valid;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        r_slot[k] <= '0;
      end
      r_busy         <= 1'b0;
      r_pending      <= '0;
      r_stall_cycles <= '0;
    end else begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        r_slot[k] <= w_slot_next[k];
      end
      r_busy    <= w_busy_next;
      r_pending <= w_pending_next;
      if (w_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + COUNT_WIDTH'(1);
      end
    end
  end

  assign sb.stallD       = w_stall;
  assign sb.flushD       = sb.takeBranchE;
  assign sb.issueAccept  = w_accept;
  assign sb.busy         = r_busy;
  assign sb.pendingCount = r_pending;
  assign sb.stallCycles  = r_stall_cycles;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: dut0 is PIPE_DEPTH=3/no bypass/4-bit counter, dut1 the same with WB bypass.
// Each driven cycle pushes its expected outputs; a negedge monitor pops and compares them.
module tb_hazard_scoreboard;
  logic clock;
  logic reset;

  hazard_scoreboard_if #(.REG_ADDRESS_WIDTH(4), .PIPE_DEPTH(3), .COUNT_WIDTH(4)) sb0 ();
  hazard_scoreboard_if #(.REG_ADDRESS_WIDTH(4), .PIPE_DEPTH(3), .COUNT_WIDTH(4)) sb1 ();

  hazard_scoreboard #(.REG_ADDRESS_WIDTH(4), .PIPE_DEPTH(3), .WB_BYPASS(1'b0), .COUNT_WIDTH(4)) dut0 (
    .clock (clock),
    .reset (reset),
    .sb    (sb0.slave)
  );

  hazard_scoreboard #(.REG_ADDRESS_WIDTH(4), .PIPE_DEPTH(3), .WB_BYPASS(1'b1), .COUNT_WIDTH(4)) dut1 (
    .clock (clock),
    .reset (reset),
    .sb    (sb1.slave)
  );

  assign sb1.issueValid            = sb0.issueValid;
  assign sb1.reg1Used              = sb0.reg1Used;
  assign sb1.reg2Used              = sb0.reg2Used;
  assign sb1.reg1Address           = sb0.reg1Address;
  assign sb1.reg2Address           = sb0.reg2Address;
  assign sb1.isScalarReg1          = sb0.isScalarReg1;
  assign sb1.isScalarReg2          = sb0.isScalarReg2;
  assign sb1.writesReg             = sb0.writesReg;
  assign sb1.regDestinationAddress = sb0.regDestinationAddress;
  assign sb1.isScalarOutput        = sb0.isScalarOutput;
  assign sb1.takeBranchE           = sb0.takeBranchE;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic       stall;
    logic       flush;
    logic       acc;
    logic       busy;
    logic [1:0] pend;
    logic [3:0] scnt;
    logic       chk1;
    logic       stall1;
    logic       acc1;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // {stall, flush, accept} and {check dut1, stall1, accept1}
  localparam logic [2:0] IDL = 3'b000, ACC = 3'b001, FLS = 3'b010, STL = 3'b100;
  localparam logic [2:0] NO1 = 3'b000, A1 = 3'b101, S1 = 3'b110;
  localparam logic [5:0] NONE = 6'd0;

  // Operand/destination encoding: {used-or-writes, scalar, addr}
  function automatic logic [5:0] sc(input int a);
    return {2'b11, a[3:0]};
  endfunction
  function automatic logic [5:0] vc(input int a);
    return {2'b10, a[3:0]};
  endfunction
  function automatic logic [5:0] unused_sc(input int a);
    return {2'b01, a[3:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input string tag, input logic rst, input logic v,
                       input logic [5:0] s1, input logic [5:0] s2, input logic [5:0] d,
                       input logic br, input logic [2:0] e_c, input logic e_busy,
                       input logic [1:0] e_pend, input logic [3:0] e_cnt, input logic [2:0] e1);
    exp_t e;
    @(posedge clock);
    #1;
    reset                     = rst;
    sb0.issueValid            = v;
    sb0.reg1Used              = s1[5];
    sb0.isScalarReg1          = s1[4];
    sb0.reg1Address           = s1[3:0];
    sb0.reg2Used              = s2[5];
    sb0.isScalarReg2          = s2[4];
    sb0.reg2Address           = s2[3:0];
    sb0.writesReg             = d[5];
    sb0.isScalarOutput        = d[4];
    sb0.regDestinationAddress = d[3:0];
    sb0.takeBranchE           = br;
    e = '{stall: e_c[2], flush: e_c[1], acc: e_c[0], busy: e_busy, pend: e_pend,
          scnt: e_cnt, chk1: e1[2], stall1: e1[1], acc1: e1[0]};
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  initial begin
    exp_t  e;
    string t;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".stallD"},       32'(sb0.stallD),       32'(e.stall));
        check({t, ".flushD"},       32'(sb0.flushD),       32'(e.flush));
        check({t, ".issueAccept"},  32'(sb0.issueAccept),  32'(e.acc));
        check({t, ".busy"},         32'(sb0.busy),         32'(e.busy));
        check({t, ".pendingCount"}, 32'(sb0.pendingCount), 32'(e.pend));
        check({t, ".stallCycles"},  32'(sb0.stallCycles),  32'(e.scnt));
        if (e.chk1) begin
          check({t, ".byp.stallD"},      32'(sb1.stallD),      32'(e.stall1));
          check({t, ".byp.issueAccept"}, 32'(sb1.issueAccept), 32'(e.acc1));
        end
      end
    end
  end

  initial begin
    reset                     = 1'b0;
    sb0.issueValid            = 1'b0;
    sb0.reg1Used              = 1'b0;
    sb0.reg2Used              = 1'b0;
    sb0.reg1Address           = '0;
    sb0.reg2Address           = '0;
    sb0.isScalarReg1          = 1'b0;
    sb0.isScalarReg2          = 1'b0;
    sb0.writesReg             = 1'b0;
    sb0.regDestinationAddress = '0;
    sb0.isScalarOutput        = 1'b0;
    sb0.takeBranchE           = 1'b0;

    // Held in reset with a matching operand: nothing tracked, nothing stalls
    drive("rst_a",   0, 1, sc(3),  NONE,  sc(3),  0, ACC, 0, 2'd0, 4'd0,  A1);
    drive("rst_b",   0, 1, sc(3),  NONE,  sc(3),  0, ACC, 0, 2'd0, 4'd0,  A1);
    // Release; source equals own destination, so no self-hazard
    drive("rel",     1, 1, sc(3),  NONE,  sc(3),  0, ACC, 0, 2'd0, 4'd0,  A1);
    // Back-to-back RAW: 3 stall cycles without bypass, 2 with
    drive("raw_s1",  1, 1, sc(3),  NONE,  NONE,   0, STL, 1, 2'd1, 4'd0,  S1);
    drive("raw_s2",  1, 1, sc(3),  NONE,  NONE,   0, STL, 1, 2'd1, 4'd1,  S1);
    drive("raw_s3",  1, 1, sc(3),  NONE,  NONE,   0, STL, 1, 2'd1, 4'd2,  A1);
    drive("raw_acc", 1, 1, sc(3),  NONE,  NONE,   0, ACC, 0, 2'd0, 4'd3,  A1);
    // Scalar/vector separation
    drive("vw",      1, 1, NONE,   NONE,  vc(3),  0, ACC, 0, 2'd0, 4'd3,  NO1);
    drive("type_sep",1, 1, sc(3),  NONE,  NONE,   0, ACC, 1, 2'd1, 4'd3,  NO1);
    drive("vraw",    1, 1, vc(3),  NONE,  NONE,   0, STL, 1, 2'd1, 4'd3,  NO1);
    drive("idle_b",  1, 0, NONE,   NONE,  NONE,   0, IDL, 1, 2'd1, 4'd4,  NO1);
    // Flush squashes the write, so the following read is free
    drive("flush_w", 1, 1, NONE,   NONE,  sc(5),  1, FLS, 0, 2'd0, 4'd4,  NO1);
    drive("flush_rd",1, 1, sc(5),  NONE,  NONE,   0, ACC, 0, 2'd0, 4'd4,  NO1);
    // Hazard coinciding with a taken branch: flush wins
    drive("br_w",    1, 1, NONE,   NONE,  sc(7),  0, ACC, 0, 2'd0, 4'd4,  NO1);
    drive("br_haz",  1, 1, sc(7),  NONE,  NONE,   1, FLS, 1, 2'd1, 4'd4,  NO1);
    drive("br_s1",   1, 1, sc(7),  NONE,  NONE,   0, STL, 1, 2'd1, 4'd4,  NO1);
    drive("br_s2",   1, 1, sc(7),  NONE,  NONE,   0, STL, 1, 2'd1, 4'd5,  NO1);
    drive("br_acc",  1, 1, sc(7),  NONE,  NONE,   0, ACC, 0, 2'd0, 4'd6,  NO1);
    // Gap of two cycles shortens the stall to two
    drive("gap_w",   1, 1, NONE,   NONE,  sc(2),  0, ACC, 0, 2'd0, 4'd6,  NO1);
    drive("gap_idle",1, 0, NONE,   NONE,  NONE,   0, IDL, 1, 2'd1, 4'd6,  NO1);
    drive("gap_s1",  1, 1, sc(2),  NONE,  NONE,   0, STL, 1, 2'd1, 4'd6,  NO1);
    drive("gap_s2",  1, 1, sc(2),  NONE,  NONE,   0, STL, 1, 2'd1, 4'd7,  NO1);
    drive("gap_acc", 1, 1, sc(2),  NONE,  NONE,   0, ACC, 0, 2'd0, 4'd8,  NO1);
    // Both sources hit different slots: wait for the later-retiring one
    drive("dual_w1", 1, 1, NONE,   NONE,  sc(1),  0, ACC, 0, 2'd0, 4'd8,  NO1);
    drive("dual_w2", 1, 1, NONE,   NONE,  vc(4),  0, ACC, 1, 2'd1, 4'd8,  NO1);
    drive("dual_s1", 1, 1, sc(1),  vc(4), NONE,   0, STL, 1, 2'd2, 4'd8,  NO1);
    drive("dual_s2", 1, 1, sc(1),  vc(4), NONE,   0, STL, 1, 2'd2, 4'd9,  NO1);
    drive("dual_s3", 1, 1, sc(1),  vc(4), NONE,   0, STL, 1, 2'd1, 4'd10, NO1);
    drive("dual_acc",1, 1, sc(1),  vc(4), NONE,   0, ACC, 0, 2'd0, 4'd11, NO1);
    // A matching address on an unread operand does not stall
    drive("unu_w",   1, 1, NONE,   NONE,  sc(6),  0, ACC, 0, 2'd0, 4'd11, NO1);
    drive("unu_rd",  1, 1, unused_sc(6), NONE, NONE, 0, ACC, 1, 2'd1, 4'd11, NO1);
    drive("unu_i1",  1, 0, NONE,   NONE,  NONE,   0, IDL, 1, 2'd1, 4'd11, NO1);
    drive("unu_i2",  1, 0, NONE,   NONE,  NONE,   0, IDL, 1, 2'd1, 4'd11, NO1);
    // Dependent write chain drives the 4-bit counter into saturation
    drive("sat_w",   1, 1, NONE,   NONE,  sc(8),  0, ACC, 0, 2'd0, 4'd11, NO1);
    drive("sat_a1",  1, 1, sc(8),  NONE,  sc(9),  0, STL, 1, 2'd1, 4'd11, NO1);
    drive("sat_a2",  1, 1, sc(8),  NONE,  sc(9),  0, STL, 1, 2'd1, 4'd12, NO1);
    drive("sat_a3",  1, 1, sc(8),  NONE,  sc(9),  0, STL, 1, 2'd1, 4'd13, NO1);
    drive("sat_a4",  1, 1, sc(8),  NONE,  sc(9),  0, ACC, 0, 2'd0, 4'd14, NO1);
    drive("sat_b1",  1, 1, sc(9),  NONE,  sc(10), 0, STL, 1, 2'd1, 4'd14, NO1);
    drive("sat_b2",  1, 1, sc(9),  NONE,  sc(10), 0, STL, 1, 2'd1, 4'd15, NO1);
    drive("sat_b3",  1, 1, sc(9),  NONE,  sc(10), 0, STL, 1, 2'd1, 4'd15, NO1);
    drive("sat_b4",  1, 1, sc(9),  NONE,  sc(10), 0, ACC, 0, 2'd0, 4'd15, NO1);
    // Reset during the second stall cycle clears everything at once
    drive("rmid_s1", 1, 1, sc(10), NONE,  NONE,   0, STL, 1, 2'd1, 4'd15, NO1);
    drive("rmid_rst",0, 1, sc(10), NONE,  NONE,   0, ACC, 0, 2'd0, 4'd0,  NO1);
    drive("rmid_rel",1, 1, sc(10), NONE,  NONE,   0, ACC, 0, 2'd0, 4'd0,  NO1);
    drive("end_idle",1, 0, NONE,   NONE,  NONE,   0, IDL, 0, 2'd0, 4'd0,  NO1);

    @(negedge clock);
    @(negedge clock);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
